cla_nibble_seq_ctrl: RTL and testbench
======================================

Name: cla_nibble_seq_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit CLA, low nibble first.
It latches the operands on start, drives one nibble pair plus the running carry to the CLA each cycle, and collects the sum nibbles.
It returns sum, cout and signed overflow with a one-cycle done pulse.
It sits between a requesting master (start/done handshake) and the shared 4-bit CLA datapath.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. Derived NIB = WIDTH/4 (local, not overridable).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only while idle
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = compute a - b (a + ~b + 1), sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results are valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry out of MSB nibble
ovf  output  1  two's-complement overflow
cla_in1  output  4  nibble of A to CLA
cla_in2  output  4  nibble of B (or ~B) to CLA
cla_cin  output  1  carry into CLA
cla_sum  input  4  CLA sum, combinational same-cycle response
cla_cout  input  1  CLA carry out, combinational same-cycle response

Behaviour:
- Reset (rst=0, async): state=IDLE, nibble index=0, carry reg=0, busy=0, done=0, sum=0, cout=0, ovf=0, cla_in1=0, cla_in2=0, cla_cin=0. Holding regs for A and B' are cleared.
- States: IDLE, RUN.
- IDLE, start=1 at edge T0:
  - A_reg<=a; B_reg<=sub ? ~b : b.
  - carry<=sub ? 1 : cin.
  - idx<=0; sum<=0; state<=RUN; busy<=1.
- RUN outputs (combinational from regs): cla_in1=A_reg[4*idx+3:4*idx], cla_in2=B_reg[4*idx+3:4*idx], cla_cin=carry.
- RUN, each edge:
  - sum[4*idx+3:4*idx]<=cla_sum; carry<=cla_cout; idx<=idx+1.
- RUN, last nibble (idx==NIB-1) at edge T0+NIB:
  - cout<=cla_cout.
  - ovf<=(A_reg[MSB]==B_reg[MSB]) && (cla_sum[3]!=A_reg[MSB]).
  - done<=1; busy<=0; state<=IDLE; idx<=0.
- Latency: start edge to done high = NIB cycles (4 for WIDTH=16). busy is high for exactly NIB cycles. Throughput is one op per NIB+... cycles; start is accepted in the cycle done is high (back-to-back ops supported).
- done is high for exactly one cycle, then 0.
- sum/cout/ovf are stable from done until the next accepted start; at that start sum clears to 0, and cout/ovf hold until the new done.
- In IDLE, cla_in1/cla_in2/cla_cin are driven 0.
- start while busy is ignored; operands and result are unaffected.
- a/b/cin/sub changes while busy have no effect (latched copies are used).
- Subtract: cout=1 means no borrow (a>=b unsigned).
- Reset asserted mid-RUN aborts immediately; all outputs return to reset values and no done is issued.
- The idx counter never exceeds NIB-1 and wraps to 0 only via completion or reset.

Test Plan:
- WIDTH=16, add 0x1234+0x4321, cin=0 -> done 4 cycles after start; sum=0x5555, cout=0, ovf=0; busy high 4 cycles; cla_in1 sequence 4,3,2,1.
- Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; cla_cin sequence 0,1,1,1. Also 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
- Sub 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Add 0x00FF+0x0001 with cin=1 -> sum=0x0101. Back-to-back: new start in the done cycle with 0x0001+0x0001 -> second done 4 cycles later, sum=0x0002.
- Start 0x1111+0x1111, then start=1 with 0xAAAA+0x5555 in its second busy cycle -> second request ignored; sum=0x2222, exactly one done pulse.
- rst=0 during the 3rd RUN cycle -> busy/done/sum/cout/ovf/cla_* go 0 asynchronously, no done pulse. After release, 0x0003+0x0004 -> sum=0x0007.

Source files
------------

// File: rtl/cla_nibble_seq_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract built on one shared external 4-bit CLA.
// Nibbles are issued low-first with the ripple carry held in a register between cycles.
module cla_nibble_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [3:0]       cla_in1,
  output logic [3:0]       cla_in2,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [NIB-1:0][3:0]  a_nib;
  logic [NIB-1:0][3:0]  b_nib;
  logic [NIB-1:0][3:0]  sum_nib;
  logic                 carry;
  logic                 last_nib;

  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic logic ovf_detect(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign last_nib = (idx == LAST_IDX);
  assign sum      = sum_nib;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_nib) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    cla_in1 = 4'd0;
    cla_in2 = 4'd0;
    cla_cin = 1'b0;
    if (state == RUN) begin
      busy    = 1'b1;
      cla_in1 = a_nib[idx];
      cla_in2 = b_nib[idx];
      cla_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_nib   <= '0;
      b_nib   <= '0;
      sum_nib <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_nib   <= a;
            b_nib   <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            idx     <= '0;
            sum_nib <= '0;
          end
        end
        RUN: begin
          sum_nib[idx] <= cla_sum;
          carry        <= cla_cout;
          if (last_nib) begin
            cout <= cla_cout;
            ovf  <= ovf_detect(a_nib[NIB-1][3], b_nib[NIB-1][3], cla_sum[3]);
            done <= 1'b1;
            idx  <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_seq_ctrl.sv
// Randomized scoreboard bench for cla_nibble_seq_ctrl with a behavioural 4-bit CLA attached.
module tb_cla_nibble_seq_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf, cla_cin, cla_cout;
  logic [W-1:0] sum;
  logic [3:0]   cla_in1, cla_in2, cla_sum;

  cla_nibble_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .cla_in1(cla_in1), .cla_in2(cla_in2), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
  );

  // The shared CLA: purely combinational 4-bit adder.
  assign {cla_cout, cla_sum} = 5'(cla_in1) + 5'(cla_in2) + 5'(cla_cin);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    int           t0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];

  // Reference model state, owned by the stimulus process.
  bit           op_live = 1'b0;
  int           op_t0 = 0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_bp = '0;
  logic         op_c0 = 1'b0;
  logic [W-1:0] res_sum = '0;
  logic         res_cout = 1'b0;
  logic         res_ovf = 1'b0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf = 1'b0;
  int           next_id = 0;
  int           first_valid = 0;

  int n_vec = 0;
  int n_err = 0;

  function automatic exp_t ref_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                  input logic ci, input logic si, input int t0, input int id);
    exp_t   r;
    longint ua, ub, sa, sb, u, s;
    ua = longint'(ai);
    ub = longint'(bi);
    sa = ai[W-1] ? ua - (longint'(1) << W) : ua;
    sb = bi[W-1] ? ub - (longint'(1) << W) : ub;
    if (si) begin
      u = ua - ub;
      s = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      u = ua + ub + longint'(ci);
      s = sa + sb + longint'(ci);
      r.cout = (u >= (longint'(1) << W));
    end
    r.sum = u[W-1:0];
    r.ovf = (s < -(longint'(1) << (W-1))) || (s > (longint'(1) << (W-1)) - 1);
    r.id  = id;
    r.t0  = t0;
    return r;
  endfunction

  function automatic logic [3:0] nib_of(input logic [W-1:0] v, input int k);
    return 4'((v >> (4 * k)) & 'hF);
  endfunction

  function automatic logic carry_into(input int k);
    longint m, t;
    m = (longint'(1) << (4 * k)) - 1;
    t = (longint'(op_a) & m) + (longint'(op_bp) & m) + longint'(op_c0);
    return t[4*k];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: per-cycle protocol checks plus scoreboard pop on every done.
  always @(negedge clk) begin
    int   k;
    bit   running;
    bit   exp_done;
    exp_t e;
    k        = cyc - op_t0;
    running  = op_live && (k < NIB);
    exp_done = op_live && (k == NIB);
    chk("busy", busy, running);
    chk("done", done, exp_done);
    if (running) begin
      chk("cla_in1", cla_in1, nib_of(op_a, k));
      chk("cla_in2", cla_in2, nib_of(op_bp, k));
      chk("cla_cin", cla_cin, carry_into(k));
    end else begin
      chk("cla_in1_idle", cla_in1, 0);
      chk("cla_in2_idle", cla_in2, 0);
      chk("cla_cin_idle", cla_cin, 0);
      chk("sum_hold", sum, op_live ? res_sum : '0);
    end
    chk("cout_hold", cout, (op_live && k >= NIB) ? res_cout : prev_cout);
    chk("ovf_hold", ovf, (op_live && k >= NIB) ? res_ovf : prev_ovf);
    if (done) begin
      while (q.size() > 0 && q[0].id < first_valid) void'(q.pop_front());
      chk("sb_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("res_sum", sum, e.sum);
        chk("res_cout", cout, e.cout);
        chk("res_ovf", ovf, e.ovf);
        chk("latency", cyc - e.t0, NIB);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci, input logic si);
    exp_t r;
    a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
    @(posedge clk);
    #1;
    if (!op_live || cyc > op_t0 + NIB) begin
      if (op_live) begin
        prev_cout = res_cout;
        prev_ovf  = res_ovf;
      end
      r = ref_op(ai, bi, ci, si, cyc, next_id);
      q.push_back(r);
      next_id++;
      op_live  = 1'b1;
      op_t0    = cyc;
      op_a     = ai;
      op_bp    = si ? ~bi : bi;
      op_c0    = si ? 1'b1 : ci;
      res_sum  = r.sum;
      res_cout = r.cout;
      res_ovf  = r.ovf;
    end
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic finish_op();
    while (op_live && cyc <= op_t0 + NIB) idle(1);
  endtask

  task automatic to_done_cycle();
    while (op_live && cyc < op_t0 + NIB) idle(1);
  endtask

  task automatic reset_now();
    rst         = 1'b0;
    op_live     = 1'b0;
    prev_cout   = 1'b0;
    prev_ovf    = 1'b0;
    first_valid = next_id;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    reset_now();

    issue(16'h1234, 16'h4321, 1'b0, 1'b0); finish_op();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); finish_op();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); finish_op();
    issue(16'h0005, 16'h0007, 1'b0, 1'b1); finish_op();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1); finish_op();
    issue(16'h0010, 16'h0003, 1'b1, 1'b1); finish_op();

    issue(16'h00FF, 16'h0001, 1'b1, 1'b0);
    to_done_cycle();
    issue(16'h0001, 16'h0001, 1'b0, 1'b0); finish_op();

    issue(16'h1111, 16'h1111, 1'b0, 1'b0);
    idle(1);
    issue(16'hAAAA, 16'h5555, 1'b0, 1'b0); finish_op();
    idle(2);

    // Abort in the third RUN cycle; outputs must clear before any further clock edge.
    issue(16'h1234, 16'h0001, 1'b0, 1'b0);
    idle(2);
    reset_now();
    issue(16'h0003, 16'h0004, 1'b0, 1'b0); finish_op();

    for (int i = 0; i < 60; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(0, NIB - 2));
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      end
      if ($urandom_range(0, 1) == 0) begin
        to_done_cycle();
      end else begin
        finish_op();
        idle($urandom_range(0, 2));
      end
    end
    finish_op();
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
